// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    localparam logic [5:0] OP_B   = 6'b000101;
    localparam logic [5:0] OP_CBZ = 6'b101101;
    localparam logic [5:0] OP_BLT = 6'b010101;

    localparam int unsigned PC_INC   = 4;
    localparam int unsigned PC_W_MAX = 64;

    // Extended to the widest supported PC; callers truncate to their PC_W.
    function automatic logic [PC_W_MAX-1:0] sext19(input logic [18:0] x);
        return {{(PC_W_MAX - 19){x[18]}}, x};
    endfunction

    function automatic logic [PC_W_MAX-1:0] sext26(input logic [25:0] x);
        return {{(PC_W_MAX - 26){x[25]}}, x};
    endfunction

endpackage

// File: rtl/br_target_calc.sv
// Branch target: PC of the EX instruction plus the sign-extended word offset.
module br_target_calc
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W = 64
) (
    input  logic [PC_W-1:0] pc_ex_i,
    input  logic            uncond_br_i,
    input  logic [18:0]     cond_addr19_i,
    input  logic [25:0]     br_addr26_i,
    output logic [PC_W-1:0] target_o
);

    logic [PC_W_MAX-1:0] off_full;
    logic [PC_W-1:0]     off_bytes;

    assign off_full  = uncond_br_i ? sext26(br_addr26_i) : sext19(cond_addr19_i);
    assign off_bytes = off_full[PC_W-1:0] << 2;
    assign target_o  = pc_ex_i + off_bytes;

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, drives imem, holds the IF/ID register and handles redirects.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W       = 64,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter bit              DELAY_SLOT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic            uncond_br_i,
    input  logic [18:0]     cond_addr19_i,
    input  logic [25:0]     br_addr26_i,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_id_o,
    output logic [PC_W-1:0] pc_id_o,
    output logic            valid_id_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_id_q, pc_id_d;
    logic [PC_W-1:0] pc_ex_q, pc_ex_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] target;
    logic            squash_id;

    br_target_calc #(
        .PC_W (PC_W)
    ) u_br_target_calc (
        .pc_ex_i       (pc_ex_q),
        .uncond_br_i   (uncond_br_i),
        .cond_addr19_i (cond_addr19_i),
        .br_addr26_i   (br_addr26_i),
        .target_o      (target)
    );

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc_id_d = pc_id_q;
        valid_d = valid_q;
        pc_ex_d = pc_ex_q;
        if (br_taken_i) begin
            // Redirect wins over stall; the word fetched this cycle is dropped.
            pc_d    = target;
            instr_d = NOP_INSTR;
            pc_id_d = pc_q;
            valid_d = 1'b0;
            pc_ex_d = pc_id_q;
        end else if (!stall_i) begin
            pc_d    = pc_q + PC_W'(PC_INC);
            instr_d = imem_rdata_i;
            pc_id_d = pc_q;
            valid_d = 1'b1;
            pc_ex_d = pc_id_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc_id_q <= '0;
            valid_q <= 1'b0;
            pc_ex_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc_id_q <= pc_id_d;
            valid_q <= valid_d;
            pc_ex_q <= pc_ex_d;
        end
    end

    // Without a delay slot the ID instruction is turned into a NOP as it moves to EX.
    assign squash_id   = br_taken_i && !DELAY_SLOT;
    assign imem_addr_o = pc_q;
    assign instr_id_o  = squash_id ? NOP_INSTR : instr_q;
    assign valid_id_o  = squash_id ? 1'b0 : valid_q;
    assign pc_id_o     = pc_id_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: delay-slot, no-delay-slot and wrapping-reset instances.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk, rst, stall, br, uncond;
    logic [18:0] c19;
    logic [25:0] b26;

    logic [63:0] a1, p1, a0, p0, aw, pw;
    logic [31:0] r1, i1, r0, i0, rw, iw;
    logic        v1, v0, vw;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [31:0] tag(input logic [63:0] a);
        return {a[15:0] ^ 16'h5A00, 16'hC0DE};
    endfunction

    assign r1 = tag(a1);
    assign r0 = tag(a0);
    assign rw = tag(aw);

    instr_fetch #(.PC_W(64), .RESET_PC(64'h0), .DELAY_SLOT(1'b1)) d1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .br_taken_i(br), .uncond_br_i(uncond),
        .cond_addr19_i(c19), .br_addr26_i(b26), .imem_addr_o(a1), .imem_rdata_i(r1),
        .instr_id_o(i1), .pc_id_o(p1), .valid_id_o(v1)
    );

    instr_fetch #(.PC_W(64), .RESET_PC(64'h0), .DELAY_SLOT(1'b0)) d0 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .br_taken_i(br), .uncond_br_i(uncond),
        .cond_addr19_i(c19), .br_addr26_i(b26), .imem_addr_o(a0), .imem_rdata_i(r0),
        .instr_id_o(i0), .pc_id_o(p0), .valid_id_o(v0)
    );

    instr_fetch #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DELAY_SLOT(1'b1)) dw (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .br_taken_i(br), .uncond_br_i(uncond),
        .cond_addr19_i(c19), .br_addr26_i(b26), .imem_addr_o(aw), .imem_rdata_i(rw),
        .instr_id_o(iw), .pc_id_o(pw), .valid_id_o(vw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset;
        rst = 1'b1; stall = 1'b0; br = 1'b0; uncond = 1'b0; c19 = '0; b26 = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_total++; if (a1 !== 64'h0) $display("FAIL rst_addr got %h exp %h", a1, 64'h0); else n_pass++;
        n_total++; if (i1 !== NOP) $display("FAIL rst_instr got %h exp %h", i1, NOP); else n_pass++;
        n_total++; if (p1 !== 64'h0) $display("FAIL rst_pc_id got %h exp %h", p1, 64'h0); else n_pass++;
        n_total++; if (v1 !== 1'b0) $display("FAIL rst_valid got %b exp 0", v1); else n_pass++;
        n_total++;
        if (aw !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL rst_addr_w got %h exp %h", aw, 64'hFFFF_FFFF_FFFF_FFFC);
        else n_pass++;
    endtask

    task automatic test_free_run;
        for (int k = 1; k <= 3; k++) begin
            logic [63:0] prev;
            prev = 64'(4 * (k - 1));
            step();
            n_total++; if (a1 !== 64'(4 * k)) $display("FAIL run_addr got %h exp %h", a1, 64'(4 * k)); else n_pass++;
            n_total++; if (i1 !== tag(prev)) $display("FAIL run_instr got %h exp %h", i1, tag(prev)); else n_pass++;
            n_total++; if (p1 !== prev) $display("FAIL run_pc_id got %h exp %h", p1, prev); else n_pass++;
            n_total++; if (v1 !== 1'b1) $display("FAIL run_valid got %b exp 1", v1); else n_pass++;
            if (k == 1) begin
                n_total++; if (aw !== 64'h0) $display("FAIL wrap_addr got %h exp 0", aw); else n_pass++;
                n_total++;
                if (pw !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_pc_id got %h exp fffffffffffffffc", pw);
                else n_pass++;
            end
        end
    endtask

    task automatic test_branch_b;
        do_reset();
        run_n(6);
        br = 1'b1; uncond = 1'b1; b26 = 26'd3;
        #1;
        n_total++; if (i1 !== tag(64'h14)) $display("FAIL b_slot_instr got %h exp %h", i1, tag(64'h14)); else n_pass++;
        n_total++; if (v1 !== 1'b1) $display("FAIL b_slot_valid got %b exp 1", v1); else n_pass++;
        n_total++; if (i0 !== NOP) $display("FAIL b_nods_instr got %h exp %h", i0, NOP); else n_pass++;
        n_total++; if (v0 !== 1'b0) $display("FAIL b_nods_valid got %b exp 0", v0); else n_pass++;
        step();
        br = 1'b0;
        n_total++; if (a1 !== 64'h1C) $display("FAIL b_target got %h exp 1c", a1); else n_pass++;
        n_total++; if (i1 !== NOP) $display("FAIL b_squash_instr got %h exp %h", i1, NOP); else n_pass++;
        n_total++; if (v1 !== 1'b0) $display("FAIL b_squash_valid got %b exp 0", v1); else n_pass++;
        step();
        n_total++; if (i1 !== tag(64'h1C)) $display("FAIL b_resume got %h exp %h", i1, tag(64'h1C)); else n_pass++;
        n_total++; if (v1 !== 1'b1) $display("FAIL b_resume_valid got %b exp 1", v1); else n_pass++;
    endtask

    task automatic test_cbz_back;
        do_reset();
        run_n(10);
        br = 1'b1; uncond = 1'b0; c19 = 19'h7FFFF;
        #1;
        n_total++; if (i0 !== NOP) $display("FAIL cbz_id_instr got %h exp %h", i0, NOP); else n_pass++;
        n_total++; if (v0 !== 1'b0) $display("FAIL cbz_id_valid got %b exp 0", v0); else n_pass++;
        n_total++; if (i1 !== tag(64'h24)) $display("FAIL cbz_ds_instr got %h exp %h", i1, tag(64'h24)); else n_pass++;
        step();
        br = 1'b0;
        n_total++; if (a0 !== 64'h1C) $display("FAIL cbz_target got %h exp 1c", a0); else n_pass++;
        n_total++; if (i0 !== NOP) $display("FAIL cbz_if_instr got %h exp %h", i0, NOP); else n_pass++;
        n_total++; if (v0 !== 1'b0) $display("FAIL cbz_if_valid got %b exp 0", v0); else n_pass++;
        n_total++; if (a1 !== 64'h1C) $display("FAIL cbz_target_ds got %h exp 1c", a1); else n_pass++;
    endtask

    task automatic test_stall;
        do_reset();
        run_n(16);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (a1 !== 64'h40) $display("FAIL stall_addr got %h exp 40", a1); else n_pass++;
            n_total++; if (p1 !== 64'h3C) $display("FAIL stall_pc_id got %h exp 3c", p1); else n_pass++;
            n_total++; if (i1 !== tag(64'h3C)) $display("FAIL stall_instr got %h exp %h", i1, tag(64'h3C)); else n_pass++;
            step();
        end
        br = 1'b1; uncond = 1'b1; b26 = 26'h3FFFFFC;
        step();
        br = 1'b0; stall = 1'b0;
        n_total++; if (a1 !== 64'h28) $display("FAIL stall_br_addr got %h exp 28", a1); else n_pass++;
        n_total++; if (v1 !== 1'b0) $display("FAIL stall_br_valid got %b exp 0", v1); else n_pass++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        run_n(2);
        br = 1'b1; uncond = 1'b1; b26 = 26'd2;
        step();
        n_total++; if (a1 !== 64'h8) $display("FAIL b2b_first got %h exp 8", a1); else n_pass++;
        n_total++; if (aw !== 64'h4) $display("FAIL b2b_wrap_first got %h exp 4", aw); else n_pass++;
        step();
        br = 1'b0;
        n_total++; if (a1 !== 64'hC) $display("FAIL b2b_second got %h exp c", a1); else n_pass++;
        n_total++; if (aw !== 64'h8) $display("FAIL b2b_wrap_second got %h exp 8", aw); else n_pass++;
    endtask

    task automatic test_async_reset;
        do_reset();
        run_n(3);
        br = 1'b1; uncond = 1'b1; b26 = 26'd5;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (a1 !== 64'h0) $display("FAIL arst_addr got %h exp 0", a1); else n_pass++;
        n_total++; if (i1 !== NOP) $display("FAIL arst_instr got %h exp %h", i1, NOP); else n_pass++;
        n_total++; if (p1 !== 64'h0) $display("FAIL arst_pc_id got %h exp 0", p1); else n_pass++;
        n_total++; if (v1 !== 1'b0) $display("FAIL arst_valid got %b exp 0", v1); else n_pass++;
        n_total++;
        if (aw !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL arst_addr_w got %h exp fffffffffffffffc", aw);
        else n_pass++;
        step();
        br = 1'b0; rst = 1'b0;
        n_total++; if (a1 !== 64'h0) $display("FAIL arst_rel_addr got %h exp 0", a1); else n_pass++;
        step();
        n_total++; if (a1 !== 64'h4) $display("FAIL arst_next_addr got %h exp 4", a1); else n_pass++;
        n_total++; if (i1 !== tag(64'h0)) $display("FAIL arst_first_instr got %h exp %h", i1, tag(64'h0)); else n_pass++;
        n_total++; if (v1 !== 1'b1) $display("FAIL arst_first_valid got %b exp 1", v1); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; uncond = 1'b0; c19 = '0; b26 = '0;
        test_reset();
        test_free_run();
        test_branch_b();
        test_cbz_back();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch front end of the 5-stage ARM pipeline.
- Owns the PC, drives the instruction-memory address, and registers the fetched word into the IF/ID register.
- It is the consumer end of the branch interface that the decode/control block produces: br_taken, uncond_br, cond_addr19 and br_addr26, all resolved in EX.
- Computes branch targets relative to the PC of the branching instruction, redirects, and squashes wrong-path fetches.

Parameters:
- PC_W, 64, PC and address width in bits.
- RESET_PC, 0, PC value loaded on reset.
- DELAY_SLOT, 1:
  - 1 = the instruction in ID when a branch resolves executes (one architectural delay slot).
  - 0 = it is squashed too.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock; asynchronous, active-high.
- stall  input  1  freeze the front end (hazard hold).
- br_taken  input  1  branch in EX is taken this cycle.
- uncond_br  input  1  1 = use br_addr26; 0 = use cond_addr19.
- cond_addr19  input  19  signed word offset, CBZ/B.cond.
- br_addr26  input  26  signed word offset, B.
- imem_addr  output  PC_W  instruction memory address; equals the PC register.
- imem_rdata  input  32  combinational instruction memory read data.
- instr_id  output  32  IF/ID instruction register.
- pc_id  output  PC_W  PC of instr_id.
- valid_id  output  1  instr_id is a real fetched instruction, not a bubble.

Behaviour:
- **Reset values** (asynchronous):
  - pc = RESET_PC.
  - instr_id = NOP_INSTR (32'hD503201F; decodes to the decoder default, so no RegWrite or MemWrite).
  - pc_id = 0, internal pc_ex = 0, valid_id = 0.
- **imem_addr** = pc, combinational. Fetch latency is 1 cycle: the word addressed in cycle n appears on instr_id in cycle n+1.
- **Internal PC pipeline:** pc_ex <= pc_id whenever ID advances, i.e. when not stalled. pc_ex is the PC of the instruction in EX, against which branches are resolved.
- **Target computation:**
  - off = uncond_br ? sext(br_addr26) : sext(cond_addr19), extended to PC_W.
  - target = pc_ex + (off << 2), modulo 2^PC_W.
- **Priority per clock edge, highest first:**
  1. **br_taken = 1** (overrides stall):
     - pc <= target.
     - IF slot is squashed: the word fetched this cycle is discarded.
     - If DELAY_SLOT = 1: instr_id, pc_id and valid_id advance normally from the current fetch only if the current instr_id has not yet entered EX. Equivalently, the existing instr_id proceeds to EX, and the new instr_id <= NOP_INSTR with valid_id <= 0.
     - If DELAY_SLOT = 0: additionally, the instruction leaving ID to EX is marked squashed (pc_ex still updated). The EX-stage squash is signalled by the decode block seeing NOP_INSTR. Concretely: instr_id <= NOP_INSTR, valid_id <= 0, and the current ID content is replaced by NOP before it advances.
  2. **stall = 1, br_taken = 0:** pc, instr_id, pc_id, valid_id and pc_ex all hold.
  3. **Otherwise:**
     - pc <= pc + 4, wrapping modulo 2^PC_W.
     - instr_id <= imem_rdata, pc_id <= pc, valid_id <= 1.
- **Repeated branches:** br_taken on consecutive cycles is honoured each cycle; the later one uses the pc_ex of its own instruction.
- **Reset mid-operation:** all state returns to reset values immediately. The first post-reset fetch is at RESET_PC; no pending redirect survives.
- **No FSM beyond the RUN behaviour above;** stall and branch are per-cycle conditions.

Decomposition:
- **fetch_pkg:**
  - NOP_INSTR.
  - Opcode constants OP_B = 6'b000101, OP_CBZ = 6'b101101, OP_BLT = 6'b010101.
  - PC increment constant 4.
  - Functions sext19 and sext26 (to PC_W).
- **Sub-module br_target_calc:** combinational; inputs pc_ex, uncond_br, cond_addr19, br_addr26; output target. Instantiated once.

Test Plan:
- Reset, then 4 free-running cycles with imem returning addr-tagged words → imem_addr 0, 4, 8, C; instr_id lags by one cycle; pc_id 0, 4, 8; valid_id 0 then 1.
- B resolved with uncond_br = 1, br_addr26 = 3, pc_ex = 0x10 → next imem_addr = 0x1C.
  - DELAY_SLOT = 1: the ID instruction at 0x14 proceeds; the next instr_id is NOP_INSTR with valid_id = 0.
- CBZ backward: uncond_br = 0, cond_addr19 = 19'h7FFFF (-1), pc_ex = 0x20 → imem_addr = 0x1C.
  - With DELAY_SLOT = 0, both wrong-path slots become NOP_INSTR with valid_id = 0.
- stall held 3 cycles at pc = 0x40 → imem_addr, instr_id and pc_id constant. stall plus br_taken in the same cycle → redirect occurs and stall is ignored.
- PC wrap: RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC, one advance → imem_addr = 0. Branch offset overflow also wraps.
- Assert rst asynchronously mid-cycle during a taken branch → outputs take reset values before the next edge; the first fetch after release is at RESET_PC.
